// File: rtl/filter_arb_ctrl_pkg.sv
// Shared definitions for the filter output-buffer arbiter: sizing defaults,
// controller state encoding and a pointer-width helper.
package MD_pkg;

    localparam int NUM_FILTERS = 4;
    localparam int NUM_CREDITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Index width that stays legal for a single filter.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filter_arb_ctrl_if.sv
// Buffer-side bus between the filter output buffers and the arbiter:
// empty flags and credit return in, pop strobes and aligned arb result out.
interface filter_arb_if #(
    parameter int NUM_FILTERS = MD_pkg::NUM_FILTERS
);
    logic [NUM_FILTERS-1:0] i_filter_buffer_empty;
    logic                   i_credit_return;
    logic [NUM_FILTERS-1:0] o_filter_buffer_rd_en;
    logic [NUM_FILTERS-1:0] o_filter_output_arb_result;

    modport master (
        input  i_filter_buffer_empty,
        input  i_credit_return,
        output o_filter_buffer_rd_en,
        output o_filter_output_arb_result
    );

    modport slave (
        output i_filter_buffer_empty,
        output i_credit_return,
        input  o_filter_buffer_rd_en,
        input  o_filter_output_arb_result
    );
endinterface

// File: rtl/filter_arb_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping, returned one-hot (all zero when nothing requests).
module rr_arbiter #(
    parameter int NUM_FILTERS = MD_pkg::NUM_FILTERS,
    parameter int PW          = MD_pkg::ptr_width(NUM_FILTERS)
) (
    input  logic [NUM_FILTERS-1:0] req,
    input  logic [PW-1:0]          ptr,
    output logic [NUM_FILTERS-1:0] gnt
);
    int idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = NUM_FILTERS; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_FILTERS;
            if (req[idx]) gnt = NUM_FILTERS'(1) << idx;
        end
    end
endmodule

// File: rtl/filter_arb_ctrl.sv
// Credit-gated round-robin arbiter that pops filter output buffers into the
// downstream force pipeline for one home-cell evaluation at a time.
module filter_arb_ctrl #(
    parameter int NUM_FILTERS = MD_pkg::NUM_FILTERS,
    parameter int NUM_CREDITS = MD_pkg::NUM_CREDITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_filter_input_done,
    filter_arb_if.master bus,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_credit_err
);
    import MD_pkg::*;

    localparam int CW = $clog2(NUM_CREDITS + 1);
    localparam int PW = ptr_width(NUM_FILTERS);
    localparam logic [CW-1:0] FULL    = CW'(NUM_CREDITS);
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_FILTERS - 1);

    arb_state_e             state, state_nxt;
    logic [CW-1:0]          credits;
    logic [PW-1:0]          ptr, gnt_idx;
    logic [NUM_FILTERS-1:0] rd_en, arb_result, req, gnt;
    logic                   grant_ok, granted, drained, credit_err;

    // The buffer popped this cycle still shows its old empty flag, so mask it.
    assign grant_ok = (state != ST_IDLE) && (credits != '0);
    assign req      = grant_ok ? (~bus.i_filter_buffer_empty & ~rd_en) : '0;
    assign granted  = |gnt;
    assign drained  = (state == ST_DRAIN) && (&bus.i_filter_buffer_empty) &&
                      (credits == FULL) && (rd_en == '0) && (arb_result == '0);

    rr_arbiter #(.NUM_FILTERS(NUM_FILTERS), .PW(PW)) u_rr (
        .req(req),
        .ptr(ptr),
        .gnt(gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_FILTERS; i++)
            if (gnt[i]) gnt_idx = PW'(i);
    end

    always_comb begin
        state_nxt = state;
        o_busy    = (state != ST_IDLE);
        o_done    = 1'b0;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_RUN;
            ST_RUN:   if (i_filter_input_done) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drained) begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            credits    <= FULL;
            ptr        <= PTR_RST;
            rd_en      <= '0;
            arb_result <= '0;
            credit_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_en      <= gnt;
            arb_result <= rd_en;
            if (granted) ptr <= gnt_idx;
            if (granted && !bus.i_credit_return) begin
                credits <= credits - CW'(1);
            end else if (!granted && bus.i_credit_return) begin
                if (credits == FULL) credit_err <= 1'b1;
                else                 credits    <= credits + CW'(1);
            end
        end
    end

    assign bus.o_filter_buffer_rd_en      = rd_en;
    assign bus.o_filter_output_arb_result = arb_result;
    assign o_credit_err                   = credit_err;
endmodule

// File: doc/filter_arb_ctrl.md
FILTER_ARB_CTRL -- requirements
Module: filter_arb_ctrl

Interface
REQ-001 SHALL take parameter NUM_FILTERS, default MD_pkg::NUM_FILTERS, number of filter output buffers arbitrated.
REQ-002 SHALL take parameter NUM_CREDITS, default 8, downstream force-pipeline input FIFO depth.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_start  in  1  one-cycle pulse, begin a home-cell evaluation.
REQ-007 i_filter_input_done  in  1  level, no further neighbours will be written to any filter.
REQ-008 i_filter_buffer_empty  in  NUM_FILTERS  per-filter output buffer empty flag.
REQ-009 i_credit_return  in  1  one downstream FIFO entry freed this cycle.
REQ-010 o_filter_buffer_rd_en  out  NUM_FILTERS  one-hot-or-zero buffer pop, registered.
REQ-011 o_filter_output_arb_result  out  NUM_FILTERS  rd_en delayed 1 cycle, aligned with buffer readout, feeds pair_select.
REQ-012 o_busy  out  1  high in RUN or DRAIN.
REQ-013 o_done  out  1  one-cycle pulse, evaluation fully drained.
REQ-014 o_credit_err  out  1  sticky, credit return at full count.

Function
REQ-015 States: IDLE, RUN, DRAIN; IDLE->RUN on i_start; RUN->DRAIN when i_filter_input_done; DRAIN->IDLE when drain condition (REQ-024) holds; i_start outside IDLE ignored.
REQ-016 Requests: req[i] = !i_filter_buffer_empty[i] AND not granted in previous cycle (1-entry empty-flag lag guard).
REQ-017 Grant only in RUN or DRAIN, only when credit count > 0; at most one bit of o_filter_buffer_rd_en high.
REQ-018 Round-robin: search starts at index after last granted filter, wraps NUM_FILTERS-1 -> 0; pointer updates only on an actual grant.
REQ-019 Grant decision registered: requests sampled cycle t -> o_filter_buffer_rd_en high cycle t+1 -> o_filter_output_arb_result same bit cycle t+2.
REQ-020 Credit counter width $clog2(NUM_CREDITS+1); decrement on grant issue, increment on i_credit_return; both same cycle -> unchanged.
REQ-021 i_credit_return while count == NUM_CREDITS and no grant -> count held, o_credit_err set until rst.
REQ-022 Credit count 0 -> no grant even with requests; resumes cycle after return.
REQ-023 Single persistent requester: granted every other cycle (REQ-016).
REQ-024 Drain condition: state DRAIN, all i_filter_buffer_empty high, credit count == NUM_CREDITS, rd_en and arb_result pipeline both zero -> o_done pulse 1 cycle, state IDLE next cycle.
REQ-025 i_filter_input_done already high on RUN entry -> DRAIN on following cycle.

Reset
REQ-026 rst: state IDLE, credits NUM_CREDITS, RR pointer NUM_FILTERS-1 (first search from 0), previous-grant 0.
REQ-027 rst: all outputs 0, including o_credit_err.
REQ-028 rst mid-RUN/DRAIN aborts immediately; in-flight arb_result dropped, no o_done.

Structure
REQ-029 Arbiter state enum and NUM_CREDITS default SHALL live in MD_pkg; NUM_FILTERS reused from MD_pkg.
REQ-030 Round-robin grant logic SHALL be sub-module rr_arbiter (req, pointer -> one-hot grant), combinational, instantiated once.

Verification (NUM_FILTERS=4, NUM_CREDITS=8)
REQ-031 All 4 buffers non-empty continuously, credits returned each cycle -> rd_en sequence 0001,0010,0100,1000,0001; arb_result same sequence 1 cycle later.
REQ-032 Only buffer 2 non-empty -> rd_en 0100,0000,0100,0000 alternating.
REQ-033 No credit returns, all buffers full -> exactly 8 grants then rd_en 0; one i_credit_return -> exactly one grant 2 cycles later.
REQ-034 i_credit_return with count 8 -> count stays 8, o_credit_err high until rst.
REQ-035 i_start, 5 entries in buffer 1, i_filter_input_done, 5 returns -> o_done single pulse after last return, o_busy low next cycle.
REQ-036 rst asserted during RUN with grants in flight -> next cycle all outputs 0, state IDLE, credits 8.
